// File: rtl/snd_sdr_arb.sv
// Two-requester SDRAM read arbiter for the sound subsystem (GA20 sample cache and sound-CPU ROM
// cache). Round-robin or fixed priority, one outstanding read, with BUSY timeout and reissue.
module snd_sdr_arb #(
    parameter bit          RR      = 1'b1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        req0,
    input  logic [24:0] addr0,
    output logic        rdy0,
    input  logic        req1,
    input  logic [24:0] addr1,
    output logic        rdy1,
    output logic [63:0] dout,
    output logic [24:0] sdr_addr,
    output logic        sdr_req,
    input  logic [63:0] sdr_data,
    input  logic        sdr_rdy,
    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StBusy, StRetry, StDone} state_e;

    state_e        state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [24:0]   addr_d;
    logic [63:0]   dout_d;
    logic          sdr_req_d, rdy0_d, rdy1_d, busy_d, terr_d;
    logic          pick;

    // Contention goes to the requester not served last (RR) or to requester 0.
    assign pick = req1 && (!req0 || (RR && !last_q));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        addr_d    = sdr_addr;
        dout_d    = dout;
        terr_d    = timeout_err;
        sdr_req_d = 1'b0;
        rdy0_d    = 1'b0;
        rdy1_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    gnt_d     = pick;
                    addr_d    = pick ? addr1 : addr0;
                    cnt_d     = '0;
                    sdr_req_d = 1'b1;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                if (sdr_rdy) begin
                    dout_d  = sdr_data;
                    rdy0_d  = !gnt_q;
                    rdy1_d  = gnt_q;
                    last_d  = gnt_q;
                    state_d = StDone;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = StRetry;
                end else begin
                    cnt_d     = cnt_q + CntW'(1);
                    sdr_req_d = 1'b1;
                end
            end
            StRetry: begin
                cnt_d     = '0;
                sdr_req_d = 1'b1;
                state_d   = StBusy;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            sdr_addr    <= '0;
            dout        <= '0;
            sdr_req     <= 1'b0;
            rdy0        <= 1'b0;
            rdy1        <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            sdr_addr    <= addr_d;
            dout        <= dout_d;
            sdr_req     <= sdr_req_d;
            rdy0        <= rdy0_d;
            rdy1        <= rdy1_d;
            busy        <= busy_d;
            timeout_err <= terr_d;
        end
    end

endmodule

// File: tb/tb_snd_sdr_arb.sv
// Bench for snd_sdr_arb: a round-robin and a fixed-priority instance run in lockstep on shared
// stimulus; expected grants, addresses and data come from a transaction-level model.
module tb_snd_sdr_arb;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset, req0, req1, sdr_rdy;
    logic [24:0] addr0, addr1;
    logic [63:0] sdr_data;

    logic        rdy0_a, rdy1_a, sdr_req_a, busy_a, terr_a;
    logic [63:0] dout_a;
    logic [24:0] sdr_addr_a;
    logic        rdy0_b, rdy1_b, sdr_req_b, busy_b, terr_b;
    logic [63:0] dout_b;
    logic [24:0] sdr_addr_b;

    int   checks = 0;
    int   failures = 0;
    logic last_a;    // model: last requester served by the round-robin instance
    logic terr_exp;  // model: sticky timeout flag

    snd_sdr_arb #(.RR(1'b1), .TIMEOUT(8)) u_rr (
        .clk_sys(clk_sys), .reset(reset),
        .req0(req0), .addr0(addr0), .rdy0(rdy0_a),
        .req1(req1), .addr1(addr1), .rdy1(rdy1_a),
        .dout(dout_a), .sdr_addr(sdr_addr_a), .sdr_req(sdr_req_a),
        .sdr_data(sdr_data), .sdr_rdy(sdr_rdy), .busy(busy_a), .timeout_err(terr_a)
    );

    snd_sdr_arb #(.RR(1'b0), .TIMEOUT(8)) u_fp (
        .clk_sys(clk_sys), .reset(reset),
        .req0(req0), .addr0(addr0), .rdy0(rdy0_b),
        .req1(req1), .addr1(addr1), .rdy1(rdy1_b),
        .dout(dout_b), .sdr_addr(sdr_addr_b), .sdr_req(sdr_req_b),
        .sdr_data(sdr_data), .sdr_rdy(sdr_rdy), .busy(busy_b), .timeout_err(terr_b)
    );

    // Arbitration rule: a lone requester wins; on contention RR favours the one not served last.
    function automatic logic pick(input logic r0, input logic r1, input logic last, input logic rr);
        if (r0 && r1) return rr ? !last : 1'b0;
        return r1;
    endfunction

    task automatic do_reset();
        @(negedge clk_sys);
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; sdr_rdy = 1'b0;
        addr0 = '0; addr1 = '0; sdr_data = '0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b0;
        last_a = 1'b1;
        terr_exp = 1'b0;
    endtask

    // Called at a negedge while both arbiters are idle and the requests are already driven.
    task automatic txn(input int lat, input logic [63:0] data, input logic drop,
                       input logic drop_mid, output logic obs_a, output logic obs_b);
        logic ga, gb;
        logic [24:0] ea, eb;
        ga = pick(req0, req1, last_a, 1'b1);
        gb = pick(req0, req1, 1'b1, 1'b0);
        ea = ga ? addr1 : addr0;
        eb = gb ? addr1 : addr0;
        @(negedge clk_sys);
        checks++;
        if ({sdr_req_a, busy_a, sdr_addr_a, sdr_req_b, sdr_addr_b} !== {2'b11, ea, 1'b1, eb}) begin
            failures++;
            $display("FAIL issue got req=%b busy=%b addr=%h addr_b=%h exp addr=%h addr_b=%h",
                     sdr_req_a, busy_a, sdr_addr_a, sdr_addr_b, ea, eb);
        end
        if (drop_mid) begin
            // Granted requester gives up and scrambles its address; the other one asks now.
            if (ga) begin req1 = 1'b0; addr1 = 25'($urandom()); req0 = 1'b1; end
            else    begin req0 = 1'b0; addr0 = 25'($urandom()); req1 = 1'b1; addr1 = 25'($urandom()); end
        end
        for (int i = 1; i < lat; i++) begin
            @(negedge clk_sys);
            checks++;
            if ({sdr_req_a, sdr_addr_a, rdy0_a, rdy1_a, rdy0_b, rdy1_b} !== {1'b1, ea, 4'b0000}) begin
                failures++;
                $display("FAIL busy_hold cyc=%0d got req=%b addr=%h rdy=%b%b exp req=1 addr=%h rdy=00",
                         i, sdr_req_a, sdr_addr_a, rdy0_a, rdy1_a, ea);
            end
        end
        sdr_rdy = 1'b1;
        sdr_data = data;
        @(negedge clk_sys);
        sdr_rdy = 1'b0;
        sdr_data = {$urandom(), $urandom()};
        obs_a = rdy1_a;
        obs_b = rdy1_b;
        checks++;
        if ({rdy0_a, rdy1_a, dout_a, sdr_req_a, busy_a, terr_a} !== {!ga, ga, data, 1'b0, 1'b1, terr_exp}) begin
            failures++;
            $display("FAIL done_a got rdy=%b%b dout=%h req=%b busy=%b terr=%b exp rdy=%b%b dout=%h terr=%b",
                     rdy0_a, rdy1_a, dout_a, sdr_req_a, busy_a, terr_a, !ga, ga, data, terr_exp);
        end
        checks++;
        if ({rdy0_b, rdy1_b, dout_b} !== {!gb, gb, data}) begin
            failures++;
            $display("FAIL done_b got rdy=%b%b dout=%h exp rdy=%b%b dout=%h",
                     rdy0_b, rdy1_b, dout_b, !gb, gb, data);
        end
        last_a = ga;
        if (drop) begin
            if (ga) req1 = 1'b0;
            else    req0 = 1'b0;
        end
        @(negedge clk_sys);
        checks++;
        if ({rdy0_a, rdy1_a, busy_a, sdr_req_a, dout_a, busy_b, dout_b} !== {4'b0000, data, 1'b0, data}) begin
            failures++;
            $display("FAIL done_gap got rdy=%b%b busy=%b req=%b dout=%h exp rdy=00 busy=0 req=0 dout=%h",
                     rdy0_a, rdy1_a, busy_a, sdr_req_a, dout_a, data);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({rdy0_a, rdy1_a, dout_a, sdr_addr_a, sdr_req_a, busy_a, terr_a,
             rdy0_b, rdy1_b, dout_b, sdr_addr_b, sdr_req_b, busy_b, terr_b} !== '0) begin
            failures++;
            $display("FAIL reset_state got dout=%h addr=%h req=%b busy=%b terr=%b exp all zero",
                     dout_a, sdr_addr_a, sdr_req_a, busy_a, terr_a);
        end
        sdr_rdy = 1'b1;
        sdr_data = 64'hdead_beef_0bad_f00d;
        @(negedge clk_sys);
        sdr_rdy = 1'b0;
        checks++;
        if ({rdy0_a, rdy1_a, busy_a, dout_a, rdy0_b, rdy1_b} !== '0) begin
            failures++;
            $display("FAIL idle_stray_rdy got rdy=%b%b busy=%b dout=%h exp all zero",
                     rdy0_a, rdy1_a, busy_a, dout_a);
        end
    endtask

    task automatic test_single();
        logic oa, ob;
        do_reset();
        req0 = 1'b1;
        addr0 = 25'h0001234;
        txn(5, 64'h1122334455667788, 1'b1, 1'b0, oa, ob);
        checks++;
        if ({oa, ob, sdr_addr_a} !== {2'b00, 25'h0001234}) begin
            failures++;
            $display("FAIL single got served=%b addr=%h exp served=0 addr=0001234", oa, sdr_addr_a);
        end
    endtask

    task automatic test_contention();
        logic oa, ob;
        logic [3:0] seq_a, seq_b;
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        addr0 = 25'($urandom()); addr1 = 25'($urandom());
        for (int i = 0; i < 4; i++) begin
            txn($urandom_range(1, 6), {$urandom(), $urandom()}, 1'b0, 1'b0, oa, ob);
            seq_a[i] = oa;
            seq_b[i] = ob;
        end
        checks++;
        if (seq_a !== 4'b1010) begin
            failures++;
            $display("FAIL rr_order got=%b exp=1010 (bit0 first)", seq_a);
        end
        checks++;
        if (seq_b !== 4'b0000) begin
            failures++;
            $display("FAIL fixed_prio got=%b exp=0000", seq_b);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic test_drop();
        logic oa, ob;
        do_reset();
        req0 = 1'b1;
        addr0 = 25'($urandom());
        txn(3, {$urandom(), $urandom()}, 1'b1, 1'b1, oa, ob);
        checks++;
        if ({oa, ob} !== 2'b00) begin
            failures++;
            $display("FAIL drop_complete got served=%b%b exp 00", oa, ob);
        end
        txn(2, {$urandom(), $urandom()}, 1'b1, 1'b0, oa, ob);
        checks++;
        if ({oa, ob} !== 2'b11) begin
            failures++;
            $display("FAIL drop_next got served=%b%b exp 11", oa, ob);
        end
    endtask

    task automatic test_timeout();
        logic [24:0] ea;
        logic [63:0] data;
        do_reset();
        req0 = 1'b1;
        ea = 25'($urandom());
        addr0 = ea;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk_sys);
            checks++;
            if ({sdr_req_a, sdr_addr_a, terr_a, rdy0_a, sdr_req_b} !== {1'b1, ea, 2'b00, 1'b1}) begin
                failures++;
                $display("FAIL timeout_wait cyc=%0d got req=%b addr=%h terr=%b exp req=1 addr=%h terr=0",
                         i, sdr_req_a, sdr_addr_a, terr_a, ea);
            end
        end
        @(negedge clk_sys);
        checks++;
        if ({sdr_req_a, busy_a, terr_a, sdr_req_b, terr_b} !== 5'b01101) begin
            failures++;
            $display("FAIL retry got req=%b busy=%b terr=%b terr_b=%b exp req=0 busy=1 terr=1",
                     sdr_req_a, busy_a, terr_a, terr_b);
        end
        @(negedge clk_sys);
        checks++;
        if ({sdr_req_a, sdr_addr_a, terr_a} !== {1'b1, ea, 1'b1}) begin
            failures++;
            $display("FAIL reissue got req=%b addr=%h terr=%b exp req=1 addr=%h terr=1",
                     sdr_req_a, sdr_addr_a, terr_a, ea);
        end
        data = {$urandom(), $urandom()};
        sdr_rdy = 1'b1;
        sdr_data = data;
        @(negedge clk_sys);
        sdr_rdy = 1'b0;
        req0 = 1'b0;
        checks++;
        if ({rdy0_a, rdy1_a, dout_a, terr_a} !== {2'b10, data, 1'b1}) begin
            failures++;
            $display("FAIL timeout_done got rdy=%b%b dout=%h terr=%b exp rdy=10 dout=%h terr=1",
                     rdy0_a, rdy1_a, dout_a, terr_a, data);
        end
        @(negedge clk_sys);
        terr_exp = 1'b1;
        last_a = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        logic oa, ob;
        req0 = 1'b1;
        addr0 = 25'($urandom());
        @(negedge clk_sys);
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        checks++;
        if ({rdy0_a, rdy1_a, dout_a, sdr_addr_a, sdr_req_a, busy_a, terr_a,
             sdr_req_b, busy_b, terr_b, dout_b} !== '0) begin
            failures++;
            $display("FAIL reset_mid got dout=%h addr=%h req=%b busy=%b terr=%b exp all zero",
                     dout_a, sdr_addr_a, sdr_req_a, busy_a, terr_a);
        end
        reset = 1'b0;
        req0 = 1'b0;
        last_a = 1'b1;
        terr_exp = 1'b0;
        sdr_rdy = 1'b1;
        sdr_data = {$urandom(), $urandom()};
        @(negedge clk_sys);
        sdr_rdy = 1'b0;
        checks++;
        if ({rdy0_a, rdy1_a, busy_a, sdr_req_a, dout_a, rdy0_b, rdy1_b} !== '0) begin
            failures++;
            $display("FAIL stray_after_reset got rdy=%b%b busy=%b dout=%h exp all zero",
                     rdy0_a, rdy1_a, busy_a, dout_a);
        end
        req1 = 1'b1;
        addr1 = 25'($urandom());
        txn(2, {$urandom(), $urandom()}, 1'b1, 1'b0, oa, ob);
    endtask

    task automatic test_random();
        logic oa, ob;
        do_reset();
        for (int n = 0; n < 24; n++) begin
            // Idle requesters may raise a request; pending ones hold request and address.
            if (!req0 && $urandom_range(0, 1) == 1) begin req0 = 1'b1; addr0 = 25'($urandom()); end
            if (!req1 && $urandom_range(0, 1) == 1) begin req1 = 1'b1; addr1 = 25'($urandom()); end
            if (!req0 && !req1) begin req0 = 1'b1; addr0 = 25'($urandom()); end
            txn($urandom_range(1, 8), {$urandom(), $urandom()}, 1'b1, 1'b0, oa, ob);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; sdr_rdy = 1'b0;
        addr0 = '0; addr1 = '0; sdr_data = '0;
        last_a = 1'b1; terr_exp = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_drop();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
